pc_sequencer: RTL and testbench



---
 rtl/pc_seq_pkg.sv | 14 +
 rtl/pc_next_logic.sv | 25 ++
 rtl/pc_sequencer.sv | 89 ++++++++
 tb/tb_pc_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_START  = 2'd0,
        ST_FETCH  = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

    localparam int              PC_WIDTH             = 8;
    localparam logic [PC_WIDTH-1:0] DEFAULT_RESET_VECTOR = 8'h00;

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC selection: absolute jump beats relative branch beats increment.
module pc_next_logic
    import pc_seq_pkg::*;
#(
    parameter int W = PC_WIDTH
) (
    input  logic [W-1:0] pc_i,
    input  logic [W-1:0] offset_i,
    input  logic         branch_i,
    input  logic         jump_i,
    input  logic [W-1:0] target_i,
    output logic [W-1:0] next_pc_o
);

    // Offset arrives already sign-extended, so a plain W-bit add with the
    // carry dropped gives the two's-complement relative target.
    always_comb begin
        next_pc_o = pc_i + W'(1);
        if (jump_i)
            next_pc_o = target_i;
        else if (branch_i)
            next_pc_o = pc_i + offset_i;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch handshake, execute wait, PC update and
// saturating retired-instruction counter.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [7:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int         WIDTH        = PC_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] Offset,
    input  logic             Branch_Taken,
    input  logic             Jump,
    input  logic [WIDTH-1:0] Jump_Target,
    input  logic             Halt,
    input  logic             Exec_Done,
    input  logic             Fetch_Ready,
    output logic             Fetch_Valid,
    output logic [WIDTH-1:0] Fetch_Addr,
    output logic [WIDTH-1:0] PC,
    output logic             Halted,
    output logic [7:0]       Instr_Count
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] next_pc;
    logic             retire;

    assign retire = (state_q == ST_EXEC) && Exec_Done;

    pc_next_logic #(.W(WIDTH)) u_next (
        .pc_i      (pc_q),
        .offset_i  (Offset),
        .branch_i  (Branch_Taken),
        .jump_i    (Jump),
        .target_i  (Jump_Target),
        .next_pc_o (next_pc)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_n)
            state_q <= ST_START;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_START:  state_d = ST_FETCH;
            ST_FETCH:  if (Fetch_Ready) state_d = ST_EXEC;
            ST_EXEC:   if (Exec_Done)   state_d = Halt ? ST_HALTED : ST_FETCH;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_START;
        endcase
    end

    // Outputs decode only from registered state so no input reaches an output.
    always_comb begin
        Fetch_Valid = (state_q == ST_FETCH);
        Halted      = (state_q == ST_HALTED);
        Fetch_Addr  = pc_q;
        PC          = pc_q;
        Instr_Count = cnt_q;
    end

    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        if (retire) begin
            pc_d = next_pc;
            if (cnt_q != 8'hFF)
                cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            pc_q  <= WIDTH'(RESET_VECTOR);
            cnt_q <= 8'h00;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer: stimulus queues expected fetch
// addresses, a negedge monitor checks every fetch transfer and hold.
module tb_pc_sequencer;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [7:0] Offset = 8'h00;
    logic       Branch_Taken = 1'b0;
    logic       Jump = 1'b0;
    logic [7:0] Jump_Target = 8'h00;
    logic       Halt = 1'b0;
    logic       Exec_Done = 1'b0;
    logic       Fetch_Ready = 1'b0;
    logic       Fetch_Valid;
    logic [7:0] Fetch_Addr;
    logic [7:0] PC;
    logic       Halted;
    logic [7:0] Instr_Count;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic       hold_q = 1'b0;
    logic [7:0] hold_addr = 8'h00;
    logic [7:0] mon_exp;

    pc_sequencer dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Offset       (Offset),
        .Branch_Taken (Branch_Taken),
        .Jump         (Jump),
        .Jump_Target  (Jump_Target),
        .Halt         (Halt),
        .Exec_Done    (Exec_Done),
        .Fetch_Ready  (Fetch_Ready),
        .Fetch_Valid  (Fetch_Valid),
        .Fetch_Addr   (Fetch_Addr),
        .PC           (PC),
        .Halted       (Halted),
        .Instr_Count  (Instr_Count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Monitor: every accepted fetch must match the head of the scoreboard,
    // and a stalled fetch must keep valid and address stable.
    always @(negedge Clk) begin
        if (hold_q) begin
            chk("fetch_hold_valid", 32'(Fetch_Valid), 32'd1);
            chk("fetch_hold_addr", 32'(Fetch_Addr), 32'(hold_addr));
        end
        hold_q    = Reset_n && Fetch_Valid && !Fetch_Ready;
        hold_addr = Fetch_Addr;
        if (Reset_n && Fetch_Valid && Fetch_Ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_fetch: got addr %0h expected no fetch", Fetch_Addr);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("fetch_addr", 32'(Fetch_Addr), 32'(mon_exp));
            end
        end
    end

    task automatic wait_fetch(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (Fetch_Valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL fetch_timeout: got Fetch_Valid=0 expected 1 within 20 cycles");
        end
    endtask

    // One instruction: fetch of exp_addr (after `stall` not-ready cycles),
    // then a single Exec_Done cycle with the given control inputs.
    task automatic do_instr(input int stall, input logic br, input logic [7:0] off,
                            input logic jmp, input logic [7:0] tgt, input logic hlt,
                            input logic [7:0] exp_addr);
        bit ok;
        exp_q.push_back(exp_addr);
        wait_fetch(ok);
        Fetch_Ready = 1'b0;
        repeat (stall) tick();
        if (stall > 0)
            chk("stall_still_fetch", 32'(Fetch_Valid), 32'd1);
        Fetch_Ready = 1'b1;
        tick();
        Fetch_Ready = 1'b0;
        chk("exec_valid_low", 32'(Fetch_Valid), 32'd0);
        Exec_Done = 1'b1; Branch_Taken = br; Offset = off;
        Jump = jmp; Jump_Target = tgt; Halt = hlt;
        tick();
        Exec_Done = 1'b0; Branch_Taken = 1'b0; Offset = 8'h00;
        Jump = 1'b0; Jump_Target = 8'h00; Halt = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"}, 32'(Fetch_Valid), 32'd0);
        chk({tag, "_pc"}, 32'(PC), 32'h00);
        chk({tag, "_halted"}, 32'(Halted), 32'd0);
        chk({tag, "_count"}, 32'(Instr_Count), 32'd0);
    endtask

    initial begin
        bit ok;
        Reset_n = 1'b0;
        tick();
        tick();
        check_reset_state("reset");
        Reset_n = 1'b1;
        tick();
        chk("first_valid", 32'(Fetch_Valid), 32'd1);

        // Free run 00..03
        for (int i = 0; i < 4; i++)
            do_instr(0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'(i));
        chk("count_after_4", 32'(Instr_Count), 32'd4);

        // Backpressure at 05
        do_instr(0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h04);
        do_instr(3, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h05);

        // Branch backwards from 00 by -2, then wrap FF -> 00
        do_instr(0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h06);
        do_instr(0, 1'b1, 8'hFE, 1'b0, 8'h00, 1'b0, 8'h00);
        do_instr(0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'hFE);
        do_instr(0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'hFF);
        do_instr(0, 1'b0, 8'h00, 1'b1, 8'h10, 1'b0, 8'h00);
        do_instr(0, 1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 8'h10);
        do_instr(0, 1'b0, 8'h00, 1'b1, 8'h20, 1'b0, 8'h11);
        // Jump beats branch at 20
        do_instr(0, 1'b1, 8'hFF, 1'b1, 8'h40, 1'b0, 8'h20);
        do_instr(0, 1'b0, 8'h00, 1'b1, 8'h07, 1'b0, 8'h40);
        // Halt at 07
        do_instr(0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h07);
        chk("halt_pc", 32'(PC), 32'h08);
        chk("halt_flag", 32'(Halted), 32'd1);
        chk("halt_count", 32'(Instr_Count), 32'd16);
        Fetch_Ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            Exec_Done = (i == 3);
            Jump = (i == 3);
            Jump_Target = 8'h99;
            tick();
            chk("halted_no_fetch", 32'(Fetch_Valid), 32'd0);
            chk("halted_stays", 32'(Halted), 32'd1);
        end
        Exec_Done = 1'b0; Jump = 1'b0; Jump_Target = 8'h00;
        Fetch_Ready = 1'b0;
        chk("halted_pc_frozen", 32'(PC), 32'h08);

        Reset_n = 1'b0;
        tick();
        check_reset_state("reset_from_halt");
        Reset_n = 1'b1;

        // Reset while fetch of 33 is pending
        do_instr(0, 1'b0, 8'h00, 1'b1, 8'h33, 1'b0, 8'h00);
        wait_fetch(ok);
        chk("pending_addr", 32'(Fetch_Addr), 32'h33);
        Reset_n = 1'b0;
        tick();
        chk("midfetch_pc", 32'(PC), 32'h00);
        chk("midfetch_valid", 32'(Fetch_Valid), 32'd0);
        Reset_n = 1'b1;

        // 300 retirements: counter saturates, PC wraps
        for (int i = 0; i < 300; i++) begin
            do_instr(0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'(i));
            if (i == 253) chk("count_254", 32'(Instr_Count), 32'hFE);
            if (i == 254) chk("count_255", 32'(Instr_Count), 32'hFF);
        end
        chk("count_sat", 32'(Instr_Count), 32'hFF);
        chk("pc_after_300", 32'(PC), 32'(8'(300)));

        tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
